// File: rtl/cubed_tile_pkg.sv
// Shared tile geometry, loader state encoding and pixel format conversions
// used by the tile writer and the tile loader.
package cubed_tile_pkg;

    localparam int TILE_W       = 32;
    localparam int TILE_H       = 32;
    localparam int FB_STRIDE_QW = 320;

    localparam int BEATS  = TILE_W / 2;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int COL_W  = $clog2(TILE_W);
    localparam int ROW_W  = $clog2(TILE_H);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(TILE_W - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(TILE_H - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_DATA  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Replicating the top bits maps 0x00 to 0x000 and 0xFF to 0x3FF exactly.
    function automatic logic [9:0] argb8_to_u10(input logic [7:0] v);
        return {v, v[7:6]};
    endfunction

    function automatic logic [63:0] pix_to_tb(input logic [31:0] pix);
        return {6'd0, argb8_to_u10(pix[31:24]),
                6'd0, argb8_to_u10(pix[23:16]),
                6'd0, argb8_to_u10(pix[15:8]),
                6'd0, argb8_to_u10(pix[7:0])};
    endfunction

    function automatic logic [7:0] u10_to_u8(input logic [15:0] v);
        logic [7:0] r;
        if (v > 16'h03FF) begin
            r = 8'hFF;
        end else begin
            r = v[9:2];
        end
        return r;
    endfunction

endpackage

// File: rtl/tile_row_buffer.sv
// One row of burst beats: written by beat index, read asynchronously by
// pixel-pair index while the row drains into the tile buffer.
module tile_row_buffer
    import cubed_tile_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [BEAT_W-1:0] wr_idx,
    input  logic [63:0]       wr_data,
    input  logic [BEAT_W-1:0] rd_idx,
    output logic [63:0]       rd_data
);

    logic [63:0] mem_r [BEATS];

    // Beat capture
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/tile_loader.sv
// Fetches one tile from the framebuffer row by row, one burst per row, and
// writes each pixel expanded to u0.10 into the tile buffer.
module tile_loader
    import cubed_tile_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        done,
    output logic        busy,
    input  logic [15:0] tile_px,
    input  logic [15:0] tile_py,
    input  logic [28:0] fb_base,
    output logic [28:0] rd_addr,
    output logic [7:0]  rd_burstcnt,
    output logic        rd_req,
    input  logic        rd_ack,
    input  logic [63:0] rd_data,
    input  logic        rd_valid,
    output logic [9:0]  tb_wr_addr,
    output logic [63:0] tb_wr_data,
    output logic        tb_wr_en
);

    state_t            state_r, next_state_s;
    logic [ROW_W-1:0]  row_r, row_nxt_s;
    logic [COL_W-1:0]  col_r, col_nxt_s;
    logic [BEAT_W-1:0] beat_r, beat_nxt_s;

    logic              rd_req_r, done_r, busy_r, tb_wr_en_r;
    logic [28:0]       rd_addr_r, rd_addr_nxt_s, row_addr_s, row_y_s;
    logic [15:0]       px_qw_s;
    logic [9:0]        tb_wr_addr_r, tb_wr_addr_nxt_s;
    logic [63:0]       tb_wr_data_r, tb_wr_data_nxt_s;
    logic [63:0]       rb_rd_data_s;
    logic [31:0]       drain_pix_s;
    logic              rb_wr_en_s;

    tile_row_buffer u_row_buffer (
        .clk     (clk),
        .wr_en   (rb_wr_en_s),
        .wr_idx  (beat_r),
        .wr_data (rd_data),
        .rd_idx  (col_nxt_s[COL_W-1:1]),
        .rd_data (rb_rd_data_s)
    );

    // State and position counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            row_r   <= '0;
            col_r   <= '0;
            beat_r  <= '0;
        end else begin
            state_r <= next_state_s;
            row_r   <= row_nxt_s;
            col_r   <= col_nxt_s;
            beat_r  <= beat_nxt_s;
        end
    end

    // Next state and next row/column/beat position
    always_comb begin
        next_state_s = state_r;
        row_nxt_s    = row_r;
        col_nxt_s    = col_r;
        beat_nxt_s   = beat_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    next_state_s = S_REQ;
                    row_nxt_s    = '0;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (rd_ack) begin
                    next_state_s = S_DATA;
                    beat_nxt_s   = '0;
                end else begin
                    next_state_s = S_REQ;
                end
            end
            S_DATA: begin
                if (rd_valid) begin
                    beat_nxt_s = beat_r + BEAT_W'(1);
                    if (beat_r == LAST_BEAT) begin
                        next_state_s = S_DRAIN;
                        col_nxt_s    = '0;
                    end else begin
                        next_state_s = S_DATA;
                    end
                end else begin
                    next_state_s = S_DATA;
                end
            end
            S_DRAIN: begin
                col_nxt_s = col_r + COL_W'(1);
                if (col_r == LAST_COL) begin
                    if (row_r == LAST_ROW) begin
                        next_state_s = S_DONE;
                    end else begin
                        next_state_s = S_REQ;
                        row_nxt_s    = row_r + ROW_W'(1);
                    end
                end else begin
                    next_state_s = S_DRAIN;
                end
            end
            S_DONE: begin
                next_state_s = S_IDLE;
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, looking at the state being entered
    always_comb begin
        px_qw_s          = tile_px >> 1;
        row_y_s          = 29'(tile_py) + 29'(row_nxt_s);
        row_addr_s       = fb_base + row_y_s * 29'(FB_STRIDE_QW) + 29'(px_qw_s);
        rd_addr_nxt_s    = rd_addr_r;
        tb_wr_addr_nxt_s = 10'd0;
        tb_wr_data_nxt_s = 64'd0;
        drain_pix_s      = 32'd0;
        if (next_state_s == S_REQ) begin
            rd_addr_nxt_s = row_addr_s;
        end else begin
            rd_addr_nxt_s = rd_addr_r;
        end
        if (next_state_s == S_DRAIN) begin
            drain_pix_s      = col_nxt_s[0] ? rb_rd_data_s[63:32] : rb_rd_data_s[31:0];
            tb_wr_addr_nxt_s = {row_nxt_s, col_nxt_s};
            tb_wr_data_nxt_s = pix_to_tb(drain_pix_s);
        end else begin
            drain_pix_s      = 32'd0;
        end
        if ((state_r == S_DATA) && rd_valid) begin
            rb_wr_en_s = 1'b1;
        end else begin
            rb_wr_en_s = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_req_r     <= 1'b0;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
            tb_wr_en_r   <= 1'b0;
            rd_addr_r    <= 29'd0;
            tb_wr_addr_r <= 10'd0;
            tb_wr_data_r <= 64'd0;
        end else begin
            rd_req_r     <= (next_state_s == S_REQ);
            done_r       <= (next_state_s == S_DONE);
            busy_r       <= (next_state_s != S_IDLE);
            tb_wr_en_r   <= (next_state_s == S_DRAIN);
            rd_addr_r    <= rd_addr_nxt_s;
            tb_wr_addr_r <= tb_wr_addr_nxt_s;
            tb_wr_data_r <= tb_wr_data_nxt_s;
        end
    end

    assign rd_req      = rd_req_r;
    assign done        = done_r;
    assign busy        = busy_r;
    assign tb_wr_en    = tb_wr_en_r;
    assign rd_addr     = rd_addr_r;
    assign tb_wr_addr  = tb_wr_addr_r;
    assign tb_wr_data  = tb_wr_data_r;
    assign rd_burstcnt = 8'(BEATS);

endmodule

// File: tb/tb_tile_loader.sv
// Randomised bench for tile_loader: a DDR read responder with configurable
// ack delay and beat gaps, and a pixel-level model of the loaded tile.
module tb_tile_loader;

    logic        clk = 1'b0;
    logic        reset, start, done, busy, rd_req, rd_ack, rd_valid, tb_wr_en;
    logic [15:0] tile_px, tile_py;
    logic [28:0] fb_base, rd_addr;
    logic [7:0]  rd_burstcnt;
    logic [63:0] rd_data, tb_wr_data;
    logic [9:0]  tb_wr_addr;

    tile_loader dut (
        .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy),
        .tile_px(tile_px), .tile_py(tile_py), .fb_base(fb_base),
        .rd_addr(rd_addr), .rd_burstcnt(rd_burstcnt), .rd_req(rd_req),
        .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
        .tb_wr_addr(tb_wr_addr), .tb_wr_data(tb_wr_data), .tb_wr_en(tb_wr_en)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, m_chk = 0, m_pass = 0;
    int ack_delay = 0, gap_pct = 0, spur_req = 0;
    bit mem_reset = 1'b1;
    int phase, cnt, rbeat, spur_done;
    logic [28:0] cur_addr;
    bit active = 1'b0;
    int wr_count = 0, ack_count = 0, uniq = 0, done_total = 0, wr_total = 0;
    bit seen [1024];
    logic [31:0] sig = 32'd0;

    // Framebuffer contents: a hash of the qword address, with one pinned pixel pair
    function automatic logic [63:0] mem_word(input logic [28:0] a);
        logic [31:0] x;
        x = {3'd0, a};
        if (a == 29'h102820) return {32'h0000_0000, 32'hFF80_00FF};
        return {x * 32'h9E37_79B1 ^ 32'h1357_9BDF, x * 32'h85EB_CA6B + 32'h2468_ACE0};
    endfunction

    function automatic logic [15:0] conv(input logic [7:0] v);
        return 16'(v) * 16'd4 + 16'(v) / 16'd64;
    endfunction

    function automatic logic [28:0] burst_addr(input int row);
        longint t;
        t = longint'(fb_base) + (longint'(tile_py) + longint'(row)) * 320 + longint'(tile_px) / 2;
        return 29'(t);
    endfunction

    task automatic cchk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    task automatic mchk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        m_chk++;
        if (ok) m_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    // DDR read responder
    initial begin
        rd_ack = 1'b0; rd_valid = 1'b0; rd_data = 64'd0;
        phase = 0; cnt = 0; rbeat = 0; spur_done = 0; cur_addr = 29'd0;
        forever begin
            @(posedge clk); #1;
            rd_ack = 1'b0; rd_valid = 1'b0;
            if (mem_reset) begin
                phase = 0;
            end else begin
                if (phase == 0 && rd_req) begin phase = 1; cnt = 0; end
                if (phase == 0) begin
                    if (spur_done < spur_req) begin
                        rd_valid = 1'b1; rd_data = 64'hDEAD_BEEF_0BAD_F00D; spur_done++;
                    end
                end else if (phase == 1) begin
                    if (cnt >= ack_delay) begin
                        rd_ack = 1'b1; cur_addr = rd_addr; rbeat = 0; phase = 2;
                    end else cnt++;
                end else begin
                    if (int'($urandom_range(0, 99)) >= gap_pct) begin
                        rd_valid = 1'b1;
                        rd_data = mem_word(cur_addr + 29'(rbeat));
                        rbeat++;
                        if (rbeat == 16) phase = 0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the tile model
    initial begin
        bit prev_rst, prev_req, prev_ack, fresh;
        int row, col;
        logic [63:0] w, exp_d;
        logic [31:0] pix;
        prev_rst = 1'b0; prev_req = 1'b0; prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                active = 1'b0;
                if (prev_rst) begin
                    cchk({rd_req, done, busy, tb_wr_en} == 4'b0000, "rst_ctl", 64'({rd_req, done, busy, tb_wr_en}), 64'd0);
                    cchk(rd_addr == 29'd0 && tb_wr_addr == 10'd0 && tb_wr_data == 64'd0, "rst_data",
                         64'(rd_addr) ^ 64'(tb_wr_addr) ^ tb_wr_data, 64'd0);
                    cchk(rd_burstcnt == 8'd16, "rst_burstcnt", 64'(rd_burstcnt), 64'd16);
                end
                prev_rst = 1'b1; prev_req = 1'b0; prev_ack = 1'b0;
            end else begin
                prev_rst = 1'b0;
                fresh = start && !busy;
                if (fresh) begin
                    active = 1'b1; wr_count = 0; ack_count = 0; uniq = 0; sig = 32'd0;
                    for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
                end
                if (active && !fresh) cchk(busy == 1'b1, "busy", 64'(busy), 64'd1);
                if (prev_req && !prev_ack) cchk(rd_req == 1'b1, "rd_req_held", 64'(rd_req), 64'd1);
                if (rd_req) begin
                    cchk(rd_addr == burst_addr(ack_count), "rd_addr", 64'(rd_addr), 64'(burst_addr(ack_count)));
                    cchk(rd_burstcnt == 8'd16, "rd_burstcnt", 64'(rd_burstcnt), 64'd16);
                    if (rd_ack) ack_count++;
                end
                prev_req = rd_req; prev_ack = rd_ack;
                if (tb_wr_en) begin
                    cchk(active && wr_count < 1024, "wr_in_load", 64'(wr_count), 64'd1023);
                    if (wr_count < 1024) begin
                        row = wr_count / 32; col = wr_count % 32;
                        w = mem_word(burst_addr(row) + 29'(col / 2));
                        pix = (col % 2 == 1) ? w[63:32] : w[31:0];
                        exp_d = {conv(pix[31:24]), conv(pix[23:16]), conv(pix[15:8]), conv(pix[7:0])};
                        cchk(tb_wr_addr == 10'(row * 32 + col), "wr_addr", 64'(tb_wr_addr), 64'(row * 32 + col));
                        cchk(tb_wr_data == exp_d, "wr_data", tb_wr_data, exp_d);
                        cchk({tb_wr_data[57:50], tb_wr_data[41:34], tb_wr_data[25:18], tb_wr_data[9:2]} == pix,
                             "round_trip", 64'({tb_wr_data[57:50], tb_wr_data[41:34], tb_wr_data[25:18], tb_wr_data[9:2]}), 64'(pix));
                        if (burst_addr(0) == 29'h102820 && wr_count == 0)
                            cchk(tb_wr_data == 64'h03FF_0202_0000_03FF, "lit_px0", tb_wr_data, 64'h03FF_0202_0000_03FF);
                        if (burst_addr(0) == 29'h102820 && wr_count == 1)
                            cchk(tb_wr_data == 64'd0, "lit_px1", tb_wr_data, 64'd0);
                        if (!seen[tb_wr_addr]) uniq++;
                        seen[tb_wr_addr] = 1'b1;
                        sig = {sig[30:0], sig[31]} ^ tb_wr_data[31:0] ^ tb_wr_data[63:32] ^ 32'(tb_wr_addr);
                    end
                    wr_count++; wr_total++;
                end
                if (done) begin
                    cchk(active && wr_count == 1024, "done_after_tile", 64'(wr_count), 64'd1024);
                    done_total++;
                    active = 1'b0;
                end
            end
        end
    end

    task automatic pulse_start;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Starts a load, optionally pins the first request, waits for done and checks the totals
    task automatic run_load(input int dly, input int gap, input bit pin, input bit poke, output int cyc);
        int d0;
        bit hit;
        ack_delay = dly; gap_pct = gap; d0 = done_total;
        pulse_start();
        if (pin) mchk(rd_req == 1'b1 && rd_addr == 29'h102820, "first_addr", 64'(rd_addr), 64'h102820);
        cyc = 0; hit = 1'b0;
        while (!hit && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
            if (poke && cyc == 100) start = 1'b1;
            else start = 1'b0;
            if (done) hit = 1'b1;
        end
        mchk(hit, "done_timeout", 64'(cyc), 64'd20000);
        repeat (6) @(posedge clk);
        #1;
        mchk(done_total - d0 == 1, "done_once", 64'(done_total - d0), 64'd1);
        mchk(wr_count == 1024 && uniq == 1024, "writes_1024_unique", 64'(wr_count) << 16 | 64'(uniq), 64'h400_0400);
        mchk(busy == 1'b0, "idle_after", 64'(busy), 64'd0);
    endtask

    initial begin
        int cyc, bound, w0, d0;
        logic [31:0] sig1;
        reset = 1'b1; start = 1'b0; tile_px = 16'd0; tile_py = 16'd0; fb_base = 29'd0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0; mem_reset = 1'b0;

        // Unstalled load, pinned addresses and cycle count
        tile_px = 16'd64; tile_py = 16'd32; fb_base = 29'h100000;
        run_load(0, 0, 1'b1, 1'b0, cyc);
        mchk(cyc + 1 == 32 * (1 + 16 + 32) + 1, "load_cycles", 64'(cyc + 1), 64'd1569);
        sig1 = sig;

        // Same tile with a slow ack and gapped beats
        run_load(7, 40, 1'b1, 1'b0, cyc);
        mchk(sig == sig1, "stalled_same_data", 64'(sig), 64'(sig1));

        // Abort during row 5 data phase, stale beats, then a fresh load near the address wrap
        tile_px = 16'(2 * $urandom_range(0, 300)); tile_py = 16'($urandom_range(0, 448));
        fb_base = 29'h1FFF_F000;
        ack_delay = 2; gap_pct = 30;
        pulse_start();
        bound = 0;
        while (ack_count < 6 && bound < 5000) begin @(posedge clk); #1; bound++; end
        mchk(ack_count >= 6, "reach_row5", 64'(ack_count), 64'd6);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1; mem_reset = 1'b1;
        w0 = wr_total; d0 = done_total;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0; mem_reset = 1'b0;
        spur_req = spur_req + 3;
        repeat (12) @(posedge clk);
        #1;
        mchk(wr_total == w0 && done_total == d0, "abort_quiet", 64'(wr_total - w0) << 8 | 64'(done_total - d0), 64'd0);
        mchk(spur_done == spur_req, "stale_beats_sent", 64'(spur_done), 64'(spur_req));
        run_load(1, 20, 1'b0, 1'b0, cyc);

        // Spurious beats while idle, start pulsed while busy
        spur_req = spur_req + 2;
        repeat (5) @(posedge clk);
        tile_px = 16'(2 * $urandom_range(0, 300)); tile_py = 16'($urandom_range(0, 448));
        fb_base = 29'($urandom);
        run_load(3, 25, 1'b0, 1'b1, cyc);

        for (int k = 0; k < 2; k++) begin
            tile_px = 16'(2 * $urandom_range(0, 32767)); tile_py = 16'($urandom);
            fb_base = 29'($urandom);
            run_load(int'($urandom_range(0, 5)), int'($urandom_range(0, 50)), 1'b0, 1'b0, cyc);
        end

        $display("%0d/%0d checks passed", n_pass + m_pass, n_chk + m_chk);
        $finish;
    end

endmodule
